i2s_rx: RTL

I2S serial audio receiver: samples an externally clocked I2S stream (sclk, lrclk, sdata) in the clk_sys domain, deserializes left and right words and presents them as a parallel stereo sample pair with a one-cycle valid strobe. It is the receive-side counterpart of the team's I2S output path. It sits between an external ADC/codec or HDMI audio extractor pin group and the core's audio mixer input.

---
 rtl/i2s_rx.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/i2s_rx.sv
// I2S receiver: synchronizes sclk/lrclk/sdata into clk_sys, deserializes Philips I2S words
// and emits a left/right pair with a one-cycle sample_valid. Optional: I2S_RX_FRAME_CHECK_EN.
module i2s_rx #(
  parameter int AUDIO_DW    = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk_sys,
  input  logic                reset,
  input  logic                sclk,
  input  logic                lrclk,
  input  logic                sdata,
  output logic [AUDIO_DW-1:0] left_chan,
  output logic [AUDIO_DW-1:0] right_chan,
  output logic                sample_valid,
  output logic                frame_err,
  output logic                state_dbg
);

  localparam int CW = $clog2(AUDIO_DW + 1);
  localparam logic [CW-1:0] DW_C = CW'(AUDIO_DW);

  typedef enum logic {
    HUNT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state;

  // Identical chains keep the three pins mutually aligned after synchronization.
  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] lrclk_sync;
  logic [SYNC_STAGES-1:0] sdata_sync;
  logic                   sclk_prev;
  logic                   rise;
  logic [1:0]             rise_d;
  logic [1:0]             lr_d;
  logic [1:0]             sd_d;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      sclk_sync  <= '0;
      lrclk_sync <= '0;
      sdata_sync <= '0;
      sclk_prev  <= 1'b0;
      rise_d     <= '0;
      lr_d       <= '0;
      sd_d       <= '0;
    end else begin
      sclk_sync  <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      lrclk_sync <= {lrclk_sync[SYNC_STAGES-2:0], lrclk};
      sdata_sync <= {sdata_sync[SYNC_STAGES-2:0], sdata};
      sclk_prev  <= sclk_sync[SYNC_STAGES-1];
      rise_d     <= {rise_d[0], rise};
      lr_d       <= {lr_d[0], lrclk_sync[SYNC_STAGES-1]};
      sd_d       <= {sd_d[0], sdata_sync[SYNC_STAGES-1]};
    end
  end

  assign rise = sclk_sync[SYNC_STAGES-1] & ~sclk_prev;

  // Two alignment stages after edge detect set the sample_valid latency to SYNC_STAGES + 2.
  logic rise_bit;
  logic lr_bit;
  logic sd_bit;
  assign rise_bit = rise_d[1];
  assign lr_bit   = lr_d[1];
  assign sd_bit   = sd_d[1];

  logic [CW-1:0]       cnt;
  logic [CW-1:0]       cnt_n;
  logic [AUDIO_DW-1:0] shreg;
  logic [AUDIO_DW-1:0] shreg_n;
  logic [AUDIO_DW-1:0] word;
  logic [AUDIO_DW-1:0] left_hold;
  logic                have_left;
  logic                lrclk_q;
  logic                boundary;
  logic                accept;

  // Bits past AUDIO_DW are dropped; cnt saturates so it never wraps.
  always_comb begin
    cnt_n   = cnt;
    shreg_n = shreg;
    if (cnt < DW_C) begin
      shreg_n = {shreg[AUDIO_DW-2:0], sd_bit};
      cnt_n   = cnt + CW'(1);
    end
    word = shreg_n << (DW_C - cnt_n);
  end

  assign boundary = lr_bit ^ lrclk_q;

`ifdef I2S_RX_FRAME_CHECK_EN
  assign accept = (cnt_n == DW_C);
`else
  assign accept = 1'b1;
`endif

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state        <= HUNT;
      cnt          <= '0;
      shreg        <= '0;
      have_left    <= 1'b0;
      lrclk_q      <= 1'b0;
      left_hold    <= '0;
      left_chan    <= '0;
      right_chan   <= '0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      if (rise_bit) begin
        lrclk_q <= lr_bit;
        case (state)
          HUNT: begin
            if (boundary) begin
              state <= RUN;
              cnt   <= '0;
              shreg <= '0;
            end
          end
          RUN: begin
            if (!boundary) begin
              cnt   <= cnt_n;
              shreg <= shreg_n;
            end else begin
              cnt   <= '0;
              shreg <= '0;
              if (!lrclk_q) begin
                left_hold <= word;
                have_left <= accept;
              end else if (have_left) begin
                have_left <= 1'b0;
                if (accept) begin
                  left_chan    <= left_hold;
                  right_chan   <= word;
                  sample_valid <= 1'b1;
                end
              end
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

`ifdef I2S_RX_FRAME_CHECK_EN
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      frame_err <= 1'b0;
    end else begin
      frame_err <= rise_bit && (state == RUN) && boundary && !accept;
    end
  end
`else
  assign frame_err = 1'b0;
`endif

  assign state_dbg = state;

endmodule
